tu_align_scheduler: RTL and testbench

Sequences trigger-unit bitslip alignment across N_CH trigger channels, one channel at a time. Sits between the processor register interface and the per-channel bitslip generators. For each enabled channel it raises that channel's bitslip enable, waits for that channel's success flag or a timeout, and retries on timeout. It records per-channel pass/fail and reports completion with a single done pulse.

---
 rtl/tu_align_scheduler.sv | 168 ++++++++++++++++
 tb/tb_tu_align_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tu_align_scheduler.sv
// Trigger-unit bitslip alignment sequencer.
// Walks the enabled channels lowest index first. Each attempt drops the channel's
// bitslip enable for a settle period, raises it, ignores success during an arming
// window, then waits for success or timeout. Timeouts are retried up to MAX_RETRY
// extra times before the channel is marked failed. One done pulse ends the run.
module tu_align_scheduler #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned ARM_DLY    = 8,
  parameter int unsigned TIMEOUT    = 20000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESET,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] tu_success,
  output logic [N_CH-1:0] bitslip_ena,
  output logic            busy,
  output logic            done,
  output logic [3:0]      cur_ch,
  output logic [N_CH-1:0] align_ok,
  output logic [N_CH-1:0] align_fail,
  output logic [7:0]      total_retries
);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StSettle,
    StArm,
    StWait,
    StDone
  } state_e;

  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] ArmLen      = 16'(ARM_DLY);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam logic [3:0]  MaxRetry    = 4'(MAX_RETRY);

  state_e          state_q;
  logic [N_CH-1:0] pending_q;
  logic [15:0]     timer_q;
  logic [3:0]      tries_q;

  logic [N_CH-1:0] cur_oh;
  logic            cur_hit;
  logic [3:0]      low_idx;

  // Lowest set bit of a channel vector.
  function automatic logic [3:0] lowest_set(input logic [N_CH-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Current-channel decode; success bits of other channels are masked off.
  always_comb begin
    cur_oh  = N_CH'(1) << cur_ch;
    cur_hit = |(tu_success & cur_oh);
    low_idx = lowest_set(pending_q);
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      timer_q       <= '0;
      tries_q       <= '0;
      bitslip_ena   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cur_ch        <= '0;
      align_ok      <= '0;
      align_fail    <= '0;
      total_retries <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        // Partial pass/fail results are kept for software to inspect.
        state_q     <= StIdle;
        bitslip_ena <= '0;
        busy        <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              pending_q     <= ch_mask;
              align_ok      <= '0;
              align_fail    <= '0;
              total_retries <= '0;
              busy          <= 1'b1;
              state_q       <= StScan;
            end
          end

          StScan: begin
            if (pending_q == '0) begin
              state_q <= StDone;
            end else begin
              cur_ch  <= low_idx;
              tries_q <= '0;
              timer_q <= '0;
              state_q <= StSettle;
            end
          end

          StSettle: begin
            bitslip_ena <= '0;
            if (timer_q == SettleLast) begin
              timer_q <= '0;
              state_q <= StArm;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end

          // Enable is high here but a stale success from an earlier run may linger.
          StArm: begin
            bitslip_ena <= cur_oh;
            if (timer_q == ArmLen) begin
              timer_q <= '0;
              state_q <= StWait;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end

          StWait: begin
            timer_q <= timer_q + 16'd1;
            if (cur_hit) begin
              align_ok    <= align_ok | cur_oh;
              pending_q   <= pending_q & ~cur_oh;
              bitslip_ena <= '0;
              state_q     <= StScan;
            end else if (timer_q == TimeoutLast) begin
              bitslip_ena <= '0;
              if (tries_q < MaxRetry) begin
                tries_q <= tries_q + 4'd1;
                if (total_retries != 8'hFF) total_retries <= total_retries + 8'd1;
                timer_q <= '0;
                state_q <= StSettle;
              end else begin
                align_fail <= align_fail | cur_oh;
                pending_q  <= pending_q & ~cur_oh;
                state_q    <= StScan;
              end
            end
          end

          StDone: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tu_align_scheduler.sv
// Self-checking bench for tu_align_scheduler: a responder models the bitslip
// generators, expected enable pulses and run results are queued at stimulus time
// and compared as the DUT produces them.
module tb_tu_align_scheduler;

  localparam int unsigned NCh       = 8;
  localparam int unsigned SettleCyc = 4;
  localparam int unsigned ArmDly    = 8;
  localparam int unsigned Timeout   = 50;
  localparam int unsigned MaxRetry  = 2;

  typedef struct {
    int ch;
    int width;
  } pulse_t;

  typedef struct {
    logic [7:0] ok;
    logic [7:0] fail;
    logic [7:0] retries;
  } res_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic           abort;
  logic [NCh-1:0] ch_mask;
  logic [NCh-1:0] tu_success;
  logic [NCh-1:0] bitslip_ena;
  logic           busy;
  logic           done;
  logic [3:0]     cur_ch;
  logic [NCh-1:0] align_ok;
  logic [NCh-1:0] align_fail;
  logic [7:0]     total_retries;

  int n_checks;
  int n_pass;

  pulse_t pq[$];
  res_t   dq[$];

  int             succ_dly[NCh];
  int             ena_cnt[NCh];
  logic [NCh-1:0] succ_hold;
  logic           mon_ign;

  tu_align_scheduler #(
    .N_CH      (NCh),
    .SETTLE_CYC(SettleCyc),
    .ARM_DLY   (ArmDly),
    .TIMEOUT   (Timeout),
    .MAX_RETRY (MaxRetry)
  ) u_dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .start        (start),
    .abort        (abort),
    .ch_mask      (ch_mask),
    .tu_success   (tu_success),
    .bitslip_ena  (bitslip_ena),
    .busy         (busy),
    .done         (done),
    .cur_ch       (cur_ch),
    .align_ok     (align_ok),
    .align_fail   (align_fail),
    .total_retries(total_retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bitslip generator model: success rises succ_dly cycles after enable rises,
  // or is held high regardless of enable when succ_hold is set.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCh; c++) begin
      if (succ_hold[c]) begin
        tu_success[c] = 1'b1;
      end else if (bitslip_ena[c] && succ_dly[c] != 0) begin
        if (ena_cnt[c] == succ_dly[c]) tu_success[c] = 1'b1;
        ena_cnt[c]++;
      end else begin
        tu_success[c] = 1'b0;
        ena_cnt[c]    = 0;
      end
    end
  end

  // Output monitor: measures enable pulses and catches done pulses.
  logic [NCh-1:0] prev_ena;
  int             width;
  initial begin
    prev_ena = '0;
    width    = 0;
  end

  always @(negedge clk) begin
    pulse_t ep;
    res_t   er;
    if (!rst) begin
      if (bitslip_ena != prev_ena) begin
        if (prev_ena != '0 && !mon_ign) begin
          if (pq.size() == 0) begin
            check_eq("ena_unexpected", 32'(prev_ena), 32'h0);
          end else begin
            ep = pq.pop_front();
            check_eq("ena_channel", 32'(prev_ena), 32'(1) << ep.ch);
            check_eq("ena_width", 32'(width), 32'(ep.width));
          end
        end
        width = 1;
      end else if (bitslip_ena != '0) begin
        width++;
      end
      prev_ena = bitslip_ena;
      if (done) begin
        if (dq.size() == 0) begin
          check_eq("done_unexpected", 32'(done), 32'h0);
        end else begin
          er = dq.pop_front();
          check_eq("done_align_ok", 32'(align_ok), 32'(er.ok));
          check_eq("done_align_fail", 32'(align_fail), 32'(er.fail));
          check_eq("done_retries", 32'(total_retries), 32'(er.retries));
          check_eq("done_busy", 32'(busy), 32'h0);
        end
      end
    end
  end

  task automatic do_start(input logic [NCh-1:0] mask);
    @(negedge clk);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ena(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bitslip_ena == '0 && k < 200);
    if (bitslip_ena == '0) check_eq("ena_rise_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    if (!done) check_eq("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int             k;
    logic [NCh-1:0] acc_ena;
    logic           acc_busy;
    logic           acc_done;

    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    ch_mask    = 8'hFF;
    tu_success = '0;
    succ_hold  = '0;
    mon_ign    = 1'b0;
    for (int c = 0; c < NCh; c++) begin
      succ_dly[c] = 0;
      ena_cnt[c]  = 0;
    end

    // 1: reset dominates a held start
    acc_ena  = '0;
    acc_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      acc_ena  |= bitslip_ena;
      acc_busy |= busy;
    end
    check_eq("rst_ena", 32'(acc_ena), 32'h0);
    check_eq("rst_busy", 32'(acc_busy), 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_ena_after", 32'(bitslip_ena), 32'h0);
    check_eq("rst_busy_after", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_cur_ch", 32'(cur_ch), 32'h0);
    check_eq("rst_align_ok", 32'(align_ok), 32'h0);
    check_eq("rst_align_fail", 32'(align_fail), 32'h0);
    check_eq("rst_retries", 32'(total_retries), 32'h0);

    // 2: two channels pass after different delays
    succ_dly[0] = 20;
    succ_dly[2] = 30;
    pq.push_back('{0, 21});
    pq.push_back('{2, 31});
    dq.push_back('{8'h05, 8'h00, 8'd0});
    do_start(8'h05);
    check_eq("t2_busy", 32'(busy), 32'h1);
    wait_ena(k);
    check_eq("t2_ena_latency", 32'(k), 32'(2 + SettleCyc));
    wait_done(2000, k);
    succ_dly[0] = 0;
    succ_dly[2] = 0;
    repeat (4) @(negedge clk);

    // 3: channel never succeeds, exhausts retries
    for (int i = 0; i <= int'(MaxRetry); i++) pq.push_back('{1, int'(ArmDly + Timeout)});
    dq.push_back('{8'h00, 8'h02, 8'(MaxRetry)});
    do_start(8'h02);
    wait_done(2000, k);
    repeat (4) @(negedge clk);

    // 4: stale success is ignored while arming
    succ_hold[3] = 1'b1;
    repeat (3) @(negedge clk);
    pq.push_back('{3, int'(ArmDly) + 1});
    dq.push_back('{8'h08, 8'h00, 8'd0});
    do_start(8'h08);
    wait_done(2000, k);
    succ_hold[3] = 1'b0;
    repeat (4) @(negedge clk);

    // 5: abort mid-run keeps partial results, emits no done
    mon_ign     = 1'b1;
    succ_dly[0] = 10;
    do_start(8'hFF);
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_ena", 32'(bitslip_ena), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_align_ok", 32'(align_ok), 32'h01);
    check_eq("abort_align_fail", 32'(align_fail), 32'h0);
    acc_done = 1'b0;
    acc_ena  = '0;
    repeat (20) begin
      @(negedge clk);
      acc_done |= done;
      acc_ena  |= bitslip_ena;
    end
    check_eq("abort_no_done", 32'(acc_done), 32'h0);
    check_eq("abort_stays_idle", 32'(acc_ena), 32'h0);
    succ_dly[0] = 0;
    mon_ign     = 1'b0;

    // 5b: a normal run after abort
    succ_dly[2] = 15;
    pq.push_back('{2, 16});
    dq.push_back('{8'h04, 8'h00, 8'd0});
    do_start(8'h04);
    wait_done(2000, k);
    succ_dly[2] = 0;
    repeat (4) @(negedge clk);

    // 6: empty mask finishes two edges after start
    dq.push_back('{8'h00, 8'h00, 8'd0});
    do_start(8'h00);
    wait_done(50, k);
    check_eq("empty_done_latency", 32'(k), 32'd2);
    repeat (4) @(negedge clk);

    // 6b: start and mask change while busy are ignored
    succ_dly[0] = 20;
    pq.push_back('{0, 21});
    dq.push_back('{8'h01, 8'h00, 8'd0});
    do_start(8'h01);
    repeat (10) @(negedge clk);
    do_start(8'hFF);
    wait_done(2000, k);
    succ_dly[0] = 0;
    repeat (20) @(negedge clk);

    check_eq("pulse_queue_empty", 32'(pq.size()), 32'h0);
    check_eq("done_queue_empty", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
